// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes the raw pins, deframes 11-bit frames
// and decodes Set-2 make/break/E0 sequences into a held key code plus press level.
module ps2_key_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       extended,
    output logic       press,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned BITS_W = 3;

    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BITS_W-1:0] LAST_BIT  = BITS_W'(7);
    localparam logic [7:0]        PFX_EXT   = 8'hE0;
    localparam logic [7:0]        PFX_BREAK = 8'hF0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // Pin synchronizers and falling-edge history
    logic clk_ff1, clk_ff2, clk_prev;
    logic dat_ff1, dat_ff2;

    // Frame and decode state
    logic [1:0]        state, state_nxt;
    logic [BITS_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic              perr, perr_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic              ext_pend, ext_pend_nxt;
    logic              brk_pend, brk_pend_nxt;

    // Next values of the registered outputs
    logic [7:0] code_nxt;
    logic       extended_nxt;
    logic       press_nxt;
    logic       code_valid_nxt;
    logic       frame_err_nxt;

    logic fe_c;
    logic data_c;

    assign fe_c   = clk_prev & ~clk_ff2;
    assign data_c = dat_ff2;

    // Two-stage synchronizers on both pins; idle-high reset avoids a false edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_ff1  <= 1'b1;
            clk_ff2  <= 1'b1;
            clk_prev <= 1'b1;
            dat_ff1  <= 1'b1;
            dat_ff2  <= 1'b1;
        end else begin
            clk_ff1  <= ps2_clk;
            clk_ff2  <= clk_ff1;
            clk_prev <= clk_ff2;
            dat_ff1  <= ps2_data;
            dat_ff2  <= dat_ff1;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            to_cnt     <= '0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            code       <= '0;
            extended   <= 1'b0;
            press      <= 1'b0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            perr       <= perr_nxt;
            to_cnt     <= to_cnt_nxt;
            ext_pend   <= ext_pend_nxt;
            brk_pend   <= brk_pend_nxt;
            code       <= code_nxt;
            extended   <= extended_nxt;
            press      <= press_nxt;
            code_valid <= code_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    // Frame FSM, timeout supervision and Set-2 sequence decode
    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shreg_nxt      = shreg;
        perr_nxt       = perr;
        to_cnt_nxt     = to_cnt;
        ext_pend_nxt   = ext_pend;
        brk_pend_nxt   = brk_pend;
        code_nxt       = code;
        extended_nxt   = extended;
        press_nxt      = press;
        code_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;

        if (fe_c || (state == S_IDLE)) begin
            to_cnt_nxt = '0;
        end else begin
            to_cnt_nxt = to_cnt + TO_W'(1);
        end

        if (fe_c) begin
            case (state)
                S_IDLE: begin
                    // A high data bit here is line noise, not a start bit
                    if (!data_c) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                S_DATA: begin
                    shreg_nxt   = {data_c, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + BITS_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    perr_nxt  = ~(^shreg ^ data_c);
                    state_nxt = S_STOP;
                end
                S_STOP: begin
                    state_nxt = S_IDLE;
                    if (data_c && !perr) begin
                        if (shreg == PFX_EXT) begin
                            ext_pend_nxt = 1'b1;
                        end else if (shreg == PFX_BREAK) begin
                            brk_pend_nxt = 1'b1;
                        end else begin
                            if (!brk_pend) begin
                                code_nxt       = shreg;
                                extended_nxt   = ext_pend;
                                press_nxt      = 1'b1;
                                code_valid_nxt = 1'b1;
                            end else if ((shreg == code) && (ext_pend == extended)) begin
                                press_nxt      = 1'b0;
                                code_valid_nxt = 1'b1;
                            end
                            ext_pend_nxt = 1'b0;
                            brk_pend_nxt = 1'b0;
                        end
                    end else begin
                        frame_err_nxt = 1'b1;
                        ext_pend_nxt  = 1'b0;
                        brk_pend_nxt  = 1'b0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end else if ((state != S_IDLE) && (to_cnt == TO_LAST)) begin
            // Abandon a stalled partial frame; prefixes already seen stay pending
            state_nxt     = S_IDLE;
            frame_err_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: a byte-level decode model predicts outputs
// every cycle, and literal expectations pin key points of each scenario.
module tb_ps2_key_rx;

    localparam int unsigned TO   = 400;
    localparam int unsigned HALF = 8;
    localparam int unsigned LAT  = 3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       extended;
    logic       press;
    logic       code_valid;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_key_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .extended   (extended),
        .press      (press),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_cv_obs = 0;
    int n_fe_obs = 0;
    bit chk_en   = 1'b0;

    // Model: key state as the decoder should see it, plus one scheduled output event
    logic [7:0] m_code  = 8'h00;
    logic       m_ext   = 1'b0;
    logic       m_press = 1'b0;
    logic       m_extp  = 1'b0;
    logic       m_brkp  = 1'b0;
    int         ev_cyc  = -1;
    logic [7:0] ev_code = 8'h00;
    logic       ev_ext  = 1'b0;
    logic       ev_press = 1'b0;
    logic       ev_cv   = 1'b0;
    logic       ev_fe   = 1'b0;

    logic [7:0] e_code  = 8'h00;
    logic       e_ext   = 1'b0;
    logic       e_press = 1'b0;
    logic       e_cv    = 1'b0;
    logic       e_fe    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic [11:0] act;
            logic [11:0] expv;
            if (cyc == ev_cyc) begin
                e_code  = ev_code;
                e_ext   = ev_ext;
                e_press = ev_press;
                e_cv    = ev_cv;
                e_fe    = ev_fe;
            end else begin
                e_cv = 1'b0;
                e_fe = 1'b0;
            end
            act  = {code, extended, press, code_valid, frame_err};
            expv = {e_code, e_ext, e_press, e_cv, e_fe};
            n_checks++;
            if (act === expv) n_pass++;
            else $display("FAIL cycle_outputs cyc=%0d got={code,ext,press,cv,ferr}=%h required=%h",
                          cyc, act, expv);
            if (code_valid === 1'b1) n_cv_obs++;
            if (frame_err === 1'b1) n_fe_obs++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s got=%0h required=%0h", name, act, expv);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Apply the decode rules to one received byte; outputs change at cycle at
    task automatic model_byte(input logic [7:0] b, input logic ok, input int at);
        logic cv;
        cv = 1'b0;
        if (!ok) begin
            m_extp = 1'b0;
            m_brkp = 1'b0;
        end else if (b == 8'hE0) begin
            m_extp = 1'b1;
        end else if (b == 8'hF0) begin
            m_brkp = 1'b1;
        end else begin
            if (!m_brkp) begin
                m_code  = b;
                m_ext   = m_extp;
                m_press = 1'b1;
                cv      = 1'b1;
            end else if (b == m_code && m_extp == m_ext) begin
                m_press = 1'b0;
                cv      = 1'b1;
            end
            m_extp = 1'b0;
            m_brkp = 1'b0;
        end
        ev_code  = m_code;
        ev_ext   = m_ext;
        ev_press = m_press;
        ev_cv    = cv;
        ev_fe    = ~ok;
        ev_cyc   = at;
    endtask

    task automatic ps2_bit(input logic b, output int fe_cyc);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        fe_cyc  = cyc;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit);
        int   fc;
        logic p;
        logic ok;
        p  = (~^b) ^ par_flip;
        ok = (^{b, p}) && stop_bit;
        ps2_bit(1'b0, fc);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], fc);
        ps2_bit(p, fc);
        ps2_data = stop_bit;
        tick(HALF);
        ps2_clk = 1'b0;
        model_byte(b, ok, cyc + LAT);
        tick(HALF);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(30);
    endtask

    initial begin
        int cv0, fe0, fc;

        // Reset with pins idle
        rst_n = 1'b0;
        tick(3);
        check("rst_outputs", 32'({code, extended, press, code_valid, frame_err}), 32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick(5);

        // Noise clock edge with data high while idle: nothing happens
        fe0 = n_fe_obs;
        ps2_bit(1'b1, fc);
        tick(20);
        check("idle_noise_no_err", 32'(n_fe_obs - fe0), 32'd0);

        // Plain make 1C
        cv0 = n_cv_obs; fe0 = n_fe_obs;
        send_frame(8'h1C, 1'b0, 1'b1);
        check("make1c_code", 32'(code), 32'h1C);
        check("make1c_ext", 32'(extended), 32'd0);
        check("make1c_press", 32'(press), 32'd1);
        check("make1c_cv_pulses", 32'(n_cv_obs - cv0), 32'd1);
        check("make1c_no_err", 32'(n_fe_obs - fe0), 32'd0);

        // Extended up-arrow make then break
        cv0 = n_cv_obs;
        send_frame(8'hE0, 1'b0, 1'b1);
        check("e0_no_pulse", 32'(n_cv_obs - cv0), 32'd0);
        check("e0_code_held", 32'(code), 32'h1C);
        send_frame(8'h75, 1'b0, 1'b1);
        check("up_make", 32'({code, extended, press}), 32'({8'h75, 1'b1, 1'b1}));
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        check("up_f0_press_held", 32'(press), 32'd1);
        send_frame(8'h75, 1'b0, 1'b1);
        check("up_break", 32'({code, extended, press}), 32'({8'h75, 1'b1, 1'b0}));
        check("up_cv_pulses", 32'(n_cv_obs - cv0), 32'd2);

        // Parity error then good 1C
        cv0 = n_cv_obs; fe0 = n_fe_obs;
        send_frame(8'h75, 1'b1, 1'b1);
        check("parity_err_pulse", 32'(n_fe_obs - fe0), 32'd1);
        check("parity_err_no_cv", 32'(n_cv_obs - cv0), 32'd0);
        check("parity_err_hold", 32'({code, extended, press}), 32'({8'h75, 1'b1, 1'b0}));
        send_frame(8'h1C, 1'b0, 1'b1);
        check("after_perr_make", 32'({code, extended, press}), 32'({8'h1C, 1'b0, 1'b1}));

        // Stop bit low
        fe0 = n_fe_obs; cv0 = n_cv_obs;
        send_frame(8'h23, 1'b0, 1'b0);
        check("stop_err_pulse", 32'(n_fe_obs - fe0), 32'd1);
        check("stop_err_code", 32'(code), 32'h1C);

        // Timeout on a partial frame, then a typematic repeat of 1C
        fe0 = n_fe_obs;
        ps2_bit(1'b0, fc);
        ps2_bit(1'b0, fc);
        ps2_bit(1'b0, fc);
        ps2_bit(1'b1, fc);
        ev_code = m_code; ev_ext = m_ext; ev_press = m_press;
        ev_cv = 1'b0; ev_fe = 1'b1;
        ev_cyc = fc + int'(TO) + int'(LAT);
        ps2_data = 1'b1;
        tick(TO + 40);
        check("timeout_pulse", 32'(n_fe_obs - fe0), 32'd1);
        cv0 = n_cv_obs;
        send_frame(8'h1C, 1'b0, 1'b1);
        check("after_to_make", 32'({code, extended, press}), 32'({8'h1C, 1'b0, 1'b1}));
        check("typematic_cv", 32'(n_cv_obs - cv0), 32'd1);

        // Break of a key other than the held one is ignored
        cv0 = n_cv_obs;
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h23, 1'b0, 1'b1);
        check("mismatch_press", 32'(press), 32'd1);
        check("mismatch_no_cv", 32'(n_cv_obs - cv0), 32'd0);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("match_break", 32'({code, press}), 32'({8'h1C, 1'b0}));
        check("match_break_cv", 32'(n_cv_obs - cv0), 32'd1);

        tick(10);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
